// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing and helpers.
// Shared by the VGA timing controller and its bench.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CW_DEF       = 4;

  function automatic int h_tot(
    int sync, int bp, int act, int fp
  );
    return sync + bp + act + fp;
  endfunction

  function automatic int v_tot(
    int sync, int bp, int act, int fp
  );
    return sync + bp + act + fp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: resettable shift register.
// DEPTH of zero degenerates to a plain wire.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = clk ^ rst;
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    // shift toward the output, idle value on reset
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++)
          sr[i] <= RST_VAL;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++)
          sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: raster counters, frame-buffer read
// pipeline and aligned sync/colour outputs.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = CW_DEF,
  parameter int RD_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scale2x,
  input  logic [3*CW-1:0]             din,
  output logic [$clog2(V_ACTIVE)-1:0] row_addr,
  output logic [$clog2(H_ACTIVE)-1:0] col_addr,
  output logic                        rdn,
  output logic [CW-1:0]               r,
  output logic [CW-1:0]               g,
  output logic [CW-1:0]               b,
  output logic                        hs,
  output logic                        vs,
  output logic                        de,
  output logic                        frame_start
);

  localparam int H_TOT = h_tot(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOT = v_tot(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int RW = $clog2(V_ACTIVE);
  localparam int AW = $clog2(H_ACTIVE);
  localparam int H_AST = H_SYNC + H_BP;
  localparam int V_AST = V_SYNC + V_BP;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [2:0] IDLE = {~HS_POL, ~VS_POL, 1'b0};

  logic [HW-1:0] hcnt, hoff;
  logic [VW-1:0] vcnt, voff;
  int            hc, vc;
  logic          mode;
  logic          h_act, v_act, origin;
  logic [RW-1:0] row_n;
  logic [AW-1:0] col_n;
  logic [2:0]    s1, s_rd;

  // raster position, line then frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign origin = (hcnt == '0) && (vcnt == '0);

  // doubling mode only changes at the frame origin
  always_ff @(posedge clk) begin
    if (rst)
      mode <= 1'b0;
    else if (origin)
      mode <= scale2x;
  end

  assign hc    = int'(hcnt);
  assign vc    = int'(vcnt);
  assign h_act = (hc >= H_AST) && (hc < H_AST + H_ACTIVE);
  assign v_act = (vc >= V_AST) && (vc < V_AST + V_ACTIVE);
  assign hoff  = hcnt - HW'(H_AST);
  assign voff  = vcnt - VW'(V_AST);
  assign col_n = mode ? AW'(hoff >> 1) : AW'(hoff);
  assign row_n = mode ? RW'(voff >> 1) : RW'(voff);

  // stage 1: address, read strobe, frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      row_addr    <= '0;
      col_addr    <= '0;
      rdn         <= 1'b1;
      frame_start <= 1'b0;
      s1          <= IDLE;
    end else begin
      row_addr    <= row_n;
      col_addr    <= col_n;
      rdn         <= ~(h_act & v_act);
      frame_start <= origin;
      s1 <= {
        (hc < H_SYNC) ? HS_POL : ~HS_POL,
        (vc < V_SYNC) ? VS_POL : ~VS_POL,
        h_act & v_act
      };
    end
  end

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (RD_LAT),
    .RST_VAL (IDLE)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .d   (s1),
    .q   (s_rd)
  );

  // output stage: capture read data beside its syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      hs        <= ~HS_POL;
      vs        <= ~VS_POL;
      de        <= 1'b0;
      {r, g, b} <= '0;
    end else begin
      hs        <= s_rd[2];
      vs        <= s_rd[1];
      de        <= s_rd[0];
      {r, g, b} <= s_rd[0] ? din : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: two small-raster instances checked
// every clock against an arithmetic raster model.
module tb_vga_timing_ctrl;

  localparam int AHS = 3, AHB = 2, AHA = 16, AHF = 2;
  localparam int AVS = 2, AVB = 2, AVA = 16, AVF = 1;
  localparam int ALAT = 2;
  localparam int AHT = 23, AFT = 483;
  localparam int BHS = 4, BHB = 2, BHA = 12, BHF = 1;
  localparam int BVS = 2, BVB = 1, BVA = 6, BVF = 1;
  localparam int BLAT = 0;
  localparam int BFT = 190;

  typedef struct {
    logic       hs, vs, de, rdn, fs;
    int         row, col;
    logic [11:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scale2x = 1'b0;
  logic chk_en = 1'b0;

  logic [11:0] din_a, din_b, pa0, pa1;
  logic [3:0]  row_a, col_a, col_b;
  logic [2:0]  row_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic rdn_a, hs_a, vs_a, de_a, fs_a;
  logic rdn_b, hs_b, vs_b, de_b, fs_b;

  int nvec = 0, nerr = 0;
  int ea = 0, eb = 0;
  bit ma [16];
  bit mb [16];

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .RD_LAT(ALAT)
  ) u_a (
    .clk(clk), .rst(rst), .scale2x(scale2x), .din(din_a),
    .row_addr(row_a), .col_addr(col_a), .rdn(rdn_a),
    .r(r_a), .g(g_a), .b(b_a), .hs(hs_a), .vs(vs_a),
    .de(de_a), .frame_start(fs_a)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .RD_LAT(BLAT)
  ) u_b (
    .clk(clk), .rst(rst), .scale2x(scale2x), .din(din_b),
    .row_addr(row_b), .col_addr(col_b), .rdn(rdn_b),
    .r(r_b), .g(g_b), .b(b_b), .hs(hs_b), .vs(vs_b),
    .de(de_b), .frame_start(fs_b)
  );

  function automatic logic [11:0] ram(
    logic [3:0] row, logic [3:0] col
  );
    return {row, col, 4'h5};
  endfunction

  // frame buffer models: latency 2 for A, 0 for B
  always @(posedge clk) begin
    pa0 <= ram(row_a, col_a);
    pa1 <= pa0;
  end
  assign din_a = pa1;
  assign din_b = ram({1'b0, row_b}, col_b);

  // position since reset and mode seen at each origin
  always @(posedge clk) begin
    if (rst) begin
      ea <= 0;
      eb <= 0;
      for (int i = 0; i < 16; i++) begin
        ma[i] <= 1'b0;
        mb[i] <= 1'b0;
      end
    end else begin
      if (ea % AFT == 0) ma[(ea / AFT) % 16] <= scale2x;
      if (eb % BFT == 0) mb[(eb / BFT) % 16] <= scale2x;
      ea <= ea + 1;
      eb <= eb + 1;
    end
  end

  function automatic bit mode_at(int p, int ft, bit m [16]);
    if (p < 0) return 1'b0;
    return m[(p / ft) % 16];
  endfunction

  function automatic exp_t mdl(
    int p, int hsw, int hbp, int hac, int hfp,
    int vsw, int vbp, int vac, int vfp,
    bit hpl, bit vpl, bit md
  );
    exp_t e;
    int ht, vt, hc, vc;
    e.hs = ~hpl; e.vs = ~vpl; e.de = 1'b0;
    e.rdn = 1'b1; e.fs = 1'b0;
    e.row = 0; e.col = 0; e.rgb = '0;
    if (p < 0) return e;
    ht = hsw + hbp + hac + hfp;
    vt = vsw + vbp + vac + vfp;
    hc = p % ht;
    vc = (p / ht) % vt;
    e.hs = (hc < hsw) ? hpl : ~hpl;
    e.vs = (vc < vsw) ? vpl : ~vpl;
    e.de = (hc >= hsw + hbp) && (hc < hsw + hbp + hac)
        && (vc >= vsw + vbp) && (vc < vsw + vbp + vac);
    e.rdn = ~e.de;
    e.fs = (p % (ht * vt) == 0);
    if (e.de) begin
      e.row = (vc - vsw - vbp) >> md;
      e.col = (hc - hsw - hbp) >> md;
      e.rgb = {4'(e.row), 4'(e.col), 4'h5};
    end
    return e;
  endfunction

  task automatic chk(
    string nm, logic [31:0] act, logic [31:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h, want %0h",
               nm, $time, act, exp);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin : cmp
    exp_t s1, sk;
    int p;
    if (chk_en) begin
      p = ea - 1;
      s1 = mdl(p, AHS, AHB, AHA, AHF, AVS, AVB, AVA, AVF,
               1'b0, 1'b0, mode_at(p, AFT, ma));
      p = ea - 2 - ALAT;
      sk = mdl(p, AHS, AHB, AHA, AHF, AVS, AVB, AVA, AVF,
               1'b0, 1'b0, mode_at(p, AFT, ma));
      chk("a_rdn", rdn_a, s1.rdn);
      chk("a_fs", fs_a, s1.fs);
      if (!s1.rdn) begin
        chk("a_row", row_a, s1.row);
        chk("a_col", col_a, s1.col);
      end
      chk("a_hs", hs_a, sk.hs);
      chk("a_vs", vs_a, sk.vs);
      chk("a_de", de_a, sk.de);
      chk("a_rgb", {r_a, g_a, b_a}, sk.rgb);
      p = eb - 1;
      s1 = mdl(p, BHS, BHB, BHA, BHF, BVS, BVB, BVA, BVF,
               1'b1, 1'b1, mode_at(p, BFT, mb));
      p = eb - 2 - BLAT;
      sk = mdl(p, BHS, BHB, BHA, BHF, BVS, BVB, BVA, BVF,
               1'b1, 1'b1, mode_at(p, BFT, mb));
      chk("b_rdn", rdn_b, s1.rdn);
      chk("b_fs", fs_b, s1.fs);
      if (!s1.rdn) begin
        chk("b_row", row_b, s1.row);
        chk("b_col", col_b, s1.col);
      end
      chk("b_hs", hs_b, sk.hs);
      chk("b_vs", vs_b, sk.vs);
      chk("b_de", de_b, sk.de);
      chk("b_rgb", {r_b, g_b, b_b}, sk.rgb);
    end
  end

  int de_ca, hs_ca, vs_ca, fs_ca, mr_a, mc_a;
  int de_cb, hs_cb, vs_cb, fs_cb, mr_b, mc_b;

  task automatic measure(int n);
    de_ca = 0; hs_ca = 0; vs_ca = 0; fs_ca = 0;
    de_cb = 0; hs_cb = 0; vs_cb = 0; fs_cb = 0;
    mr_a = -1; mc_a = -1; mr_b = -1; mc_b = -1;
    repeat (n) begin
      @(negedge clk);
      if (de_a === 1'b1) de_ca++;
      if (hs_a === 1'b0) hs_ca++;
      if (vs_a === 1'b0) vs_ca++;
      if (fs_a === 1'b1) fs_ca++;
      if (rdn_a === 1'b0) begin
        if (int'(row_a) > mr_a) mr_a = int'(row_a);
        if (int'(col_a) > mc_a) mc_a = int'(col_a);
      end
      if (de_b === 1'b1) de_cb++;
      if (hs_b === 1'b1) hs_cb++;
      if (vs_b === 1'b1) vs_cb++;
      if (fs_b === 1'b1) fs_cb++;
      if (rdn_b === 1'b0) begin
        if (int'(row_b) > mr_b) mr_b = int'(row_b);
        if (int'(col_b) > mc_b) mc_b = int'(col_b);
      end
    end
  endtask

  task automatic wait_fs_a(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fs_a !== 1'b1 && n < 2 * AFT);
  endtask

  initial begin : stim
    int n, k;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_hs_a", hs_a, 1);
    chk("rst_vs_a", vs_a, 1);
    chk("rst_hs_b", hs_b, 0);
    chk("rst_vs_b", vs_b, 0);
    chk("rst_rdn_a", rdn_a, 1);
    chk("rst_de_a", de_a, 0);
    chk("rst_fs_a", fs_a, 0);
    chk("rst_rgb_a", {r_a, g_a, b_a}, 0);
    chk("rst_addr_a", {row_a, col_a}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("fs_first_a", fs_a, 1);
    chk("fs_first_b", fs_b, 1);

    n = 0;
    while (de_a !== 1'b1 && n < 2 * AFT) begin
      @(negedge clk);
      n++;
    end
    chk("first_px_a", {de_a, r_a, g_a, b_a}, {1'b1, 12'h005});
    k = 1;
    while (k < AHA * AVA && n < 4 * AFT) begin
      @(negedge clk);
      n++;
      if (de_a === 1'b1) k++;
    end
    chk("last_px_a", {de_a, r_a, g_a, b_a}, {1'b1, 12'hFF5});

    repeat (10) @(negedge clk);
    measure(AFT);
    chk("de_cnt_a", de_ca, 256);
    chk("hs_cnt_a", hs_ca, 63);
    chk("vs_cnt_a", vs_ca, 46);
    chk("fs_cnt_a", fs_ca, 1);
    chk("max_row_a", mr_a, 15);
    chk("max_col_a", mc_a, 15);
    measure(BFT);
    chk("de_cnt_b", de_cb, 72);
    chk("hs_cnt_b", hs_cb, 40);
    chk("vs_cnt_b", vs_cb, 38);
    chk("fs_cnt_b", fs_cb, 1);
    chk("max_row_b", mr_b, 5);
    chk("max_col_b", mc_b, 11);

    @(posedge clk);
    #1 rst = 1'b1;
    scale2x = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    measure(AFT);
    chk("x2_row_a", mr_a, 7);
    chk("x2_col_a", mc_a, 7);
    chk("x2_de_a", de_ca, 256);
    measure(BFT);
    chk("x2_row_b", mr_b, 2);
    chk("x2_col_b", mc_b, 5);
    chk("x2_de_b", de_cb, 72);

    wait_fs_a(n);
    chk("fs_seen_1", fs_a, 1);
    repeat (10 * AHT) @(posedge clk);
    #1 scale2x = 1'b0;
    measure(9 * AHT);
    chk("hold_row_a", mr_a, 7);
    measure(AFT + AHT);
    chk("new_row_a", mr_a, 15);
    chk("new_col_a", mc_a, 15);

    wait_fs_a(n);
    chk("fs_seen_2", fs_a, 1);
    repeat (12 * AHT + 10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_hs_a", hs_a, 1);
    chk("rst2_de_a", de_a, 0);
    chk("rst2_rdn_a", rdn_a, 1);
    chk("rst2_rgb_a", {r_a, g_a, b_a}, 0);
    chk("rst2_hs_b", hs_b, 0);
    @(posedge clk);
    @(negedge clk);
    chk("fs_rst_a", fs_a, 1);
    wait_fs_a(n);
    chk("frame_gap_a", n, AFT);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
